// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared servo PWM constants, direction codes and FSM encoding
package servo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } servo_state_t;

    localparam logic [2:0] POS_IZQ    = 3'b100;
    localparam logic [2:0] POS_FRENTE = 3'b010;
    localparam logic [2:0] POS_DER    = 3'b001;

    localparam int HI_W  = 17;
    localparam int PER_W = 21;

    // Defaults at 50 MHz; the servo encoders use the same values.
    localparam logic [HI_W-1:0]  DEF_MIN_W   = 17'd25_000;
    localparam logic [HI_W-1:0]  DEF_MAX_W   = 17'd125_000;
    localparam logic [HI_W-1:0]  DEF_TH_LO   = 17'd62_500;
    localparam logic [HI_W-1:0]  DEF_TH_HI   = 17'd87_500;
    localparam logic [PER_W-1:0] DEF_TIMEOUT = 21'd1_250_000;

    function automatic logic [2:0] pos_of(
        input logic [HI_W-1:0] w,
        input logic [HI_W-1:0] th_lo,
        input logic [HI_W-1:0] th_hi
    );
        if (w < th_lo)
            return POS_IZQ;
        else if (w > th_hi)
            return POS_DER;
        else
            return POS_FRENTE;
    endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// rtl/pwm_edge_sync.sv - 2-FF synchronizer with rise/fall strobe detection
module pwm_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall,
    output logic level
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    // Reset to "high" so a line already high at reset release is never seen as a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= d;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign rise  = r_sync2 & ~r_prev;
    assign fall  = ~r_sync2 & r_prev;
    assign level = r_sync2;

endmodule

// File: rtl/servo_pwm_decoder.sv
// rtl/servo_pwm_decoder.sv - measures servo PWM high time and recovers the direction code
module servo_pwm_decoder
    import servo_pkg::*;
#(
    parameter logic [HI_W-1:0]  MIN_W   = DEF_MIN_W,
    parameter logic [HI_W-1:0]  MAX_W   = DEF_MAX_W,
    parameter logic [HI_W-1:0]  TH_LO   = DEF_TH_LO,
    parameter logic [HI_W-1:0]  TH_HI   = DEF_TH_HI,
    parameter logic [PER_W-1:0] TIMEOUT = DEF_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pwm_in,
    output logic [HI_W-1:0] width_cyc,
    output logic [2:0]      pos_code,
    output logic            valid,
    output logic            err,
    output logic            lost
);

    logic w_rise;
    logic w_fall;
    logic w_level;

    pwm_edge_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pwm_in),
        .rise  (w_rise),
        .fall  (w_fall),
        .level (w_level)
    );

    servo_state_t     r_state, w_state_nxt;
    logic [HI_W-1:0]  r_hi_cnt, w_hi_nxt;
    logic [PER_W-1:0] r_per_cnt, w_per_nxt;
    logic [HI_W-1:0]  r_width, w_width_nxt;
    logic [2:0]       r_pos, w_pos_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_err, w_err_nxt;
    logic             r_lost, w_lost_nxt;

    logic [HI_W-1:0]  w_hi_inc;
    logic [PER_W-1:0] w_per_inc;
    logic             w_timeout;
    logic             w_in_range;
    logic             w_unused;

    assign w_hi_inc   = (r_hi_cnt == {HI_W{1'b1}}) ? r_hi_cnt : r_hi_cnt + 1'b1;
    assign w_per_inc  = r_per_cnt + 1'b1;
    assign w_timeout  = (r_per_cnt == TIMEOUT);
    assign w_in_range = (r_hi_cnt >= MIN_W) && (r_hi_cnt <= MAX_W);
    assign w_unused   = w_level;

    always_comb begin
        w_state_nxt = r_state;
        w_hi_nxt    = r_hi_cnt;
        w_per_nxt   = r_per_cnt;
        w_width_nxt = r_width;
        w_pos_nxt   = r_pos;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        w_lost_nxt  = r_lost;

        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_HIGH;
                    w_hi_nxt    = 17'd1;
                    w_per_nxt   = 21'd1;
                end
            end
            ST_HIGH: begin
                // Timeout takes priority over a coincident fall.
                if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_lost_nxt  = 1'b1;
                end else if (w_fall) begin
                    w_state_nxt = ST_LOW;
                    w_per_nxt   = w_per_inc;
                    if (w_in_range) begin
                        w_width_nxt = r_hi_cnt;
                        w_pos_nxt   = pos_of(r_hi_cnt, TH_LO, TH_HI);
                        w_valid_nxt = 1'b1;
                        w_lost_nxt  = 1'b0;
                    end else begin
                        w_err_nxt   = 1'b1;
                    end
                end else begin
                    w_hi_nxt    = w_hi_inc;
                    w_per_nxt   = w_per_inc;
                end
            end
            ST_LOW: begin
                if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_lost_nxt  = 1'b1;
                end else if (w_rise) begin
                    w_state_nxt = ST_HIGH;
                    w_hi_nxt    = 17'd1;
                    w_per_nxt   = 21'd1;
                end else begin
                    w_per_nxt   = w_per_inc;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_hi_cnt  <= '0;
            r_per_cnt <= '0;
            r_width   <= '0;
            r_pos     <= POS_FRENTE;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_lost    <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_hi_cnt  <= w_hi_nxt;
            r_per_cnt <= w_per_nxt;
            r_width   <= w_width_nxt;
            r_pos     <= w_pos_nxt;
            r_valid   <= w_valid_nxt;
            r_err     <= w_err_nxt;
            r_lost    <= w_lost_nxt;
        end
    end

    assign width_cyc = r_width;
    assign pos_code  = r_pos;
    assign valid     = r_valid;
    assign err       = r_err;
    assign lost      = r_lost;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// tb/tb_servo_pwm_decoder.sv - scoreboard bench for servo_pwm_decoder at 1/100 time scale
module tb_servo_pwm_decoder;

    localparam int MIN_W   = 250;
    localparam int MAX_W   = 1250;
    localparam int TH_LO   = 625;
    localparam int TH_HI   = 875;
    localparam int TIMEOUT = 5000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pwm_in = 1'b0;
    logic [16:0] width_cyc;
    logic [2:0]  pos_code;
    logic        valid;
    logic        err;
    logic        lost;

    servo_pwm_decoder #(
        .MIN_W   (17'(MIN_W)),
        .MAX_W   (17'(MAX_W)),
        .TH_LO   (17'(TH_LO)),
        .TH_HI   (17'(TH_HI)),
        .TIMEOUT (21'(TIMEOUT))
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwm_in    (pwm_in),
        .width_cyc (width_cyc),
        .pos_code  (pos_code),
        .valid     (valid),
        .err       (err),
        .lost      (lost)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_valid;
        logic [16:0] width;
        logic [2:0]  pos;
        bit          lost;
        int          fall_cyc;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: what the outputs should hold after the pulses issued so far.
    int       m_width = 0;
    bit [2:0] m_pos = 3'b010;
    bit       m_lost = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit [2:0] model_pos(input int w);
        if (w < TH_LO) return 3'b100;
        if (w > TH_HI) return 3'b001;
        return 3'b010;
    endfunction

    task automatic push(input int w);
        exp_t e;
        e.fall_cyc = cyc;
        if (w >= MIN_W && w <= MAX_W) begin
            m_width = w;
            m_pos   = model_pos(w);
            m_lost  = 1'b0;
            e.is_valid = 1'b1;
        end else begin
            e.is_valid = 1'b0;
        end
        e.width = 17'(m_width);
        e.pos   = m_pos;
        e.lost  = m_lost;
        sb.push_back(e);
    endtask

    task automatic pulse(input int w, input int lo);
        @(negedge clk);
        pwm_in = 1'b1;
        repeat (w) @(negedge clk);
        pwm_in = 1'b0;
        push(w);
        repeat (lo) @(negedge clk);
    endtask

    task automatic check_held(input string tag);
        check({tag, "_width"}, int'(width_cyc), m_width);
        check({tag, "_pos"}, int'(pos_code), int'(m_pos));
        check({tag, "_lost"}, int'(lost), int'(m_lost));
    endtask

    exp_t mon_e;
    int   mon_lat;
    always @(negedge clk) begin
        if (valid || err) begin
            check("valid_err_exclusive", int'(valid & err), 0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: valid=%0d err=%0d width=%0d at cycle %0d, none expected",
                         valid, err, width_cyc, cyc);
            end else begin
                mon_e = sb.pop_front();
                mon_lat = cyc - mon_e.fall_cyc;
                check("event_kind_valid", int'(valid), int'(mon_e.is_valid));
                check("width_cyc", int'(width_cyc), int'(mon_e.width));
                check("pos_code", int'(pos_code), int'(mon_e.pos));
                check("lost", int'(lost), int'(mon_e.lost));
                check("latency_in_3_to_5", int'(mon_lat >= 3 && mon_lat <= 5), 1);
            end
        end
    end

    int dir_w[] = '{750, 750, 750, 500, 1000, 625, 875, 624, 876,
                    250, 1250, 249, 1251, 150, 1500};
    int c0;

    initial begin
        repeat (4) @(negedge clk);
        #1;
        check("rst_width", int'(width_cyc), 0);
        check("rst_pos", int'(pos_code), 3'b010);
        check("rst_valid", int'(valid), 0);
        check("rst_err", int'(err), 0);
        check("rst_lost", int'(lost), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_lost", int'(lost), 1);

        foreach (dir_w[i]) begin
            pulse(dir_w[i], 800);
            check_held("after_dir");
        end

        for (int i = 0; i < 10; i++)
            pulse($urandom_range(150, 1500), $urandom_range(300, 1500));

        // Signal loss: last rise is at c0; lost must rise exactly TIMEOUT+1 after the synchronized rise.
        pulse(750, 500);
        @(negedge clk);
        pwm_in = 1'b1;
        c0 = cyc;
        repeat (750) @(negedge clk);
        pwm_in = 1'b0;
        push(750);
        while (cyc < c0 + 2 + TIMEOUT) @(negedge clk);
        check("lost_before_timeout", int'(lost), 0);
        @(negedge clk);
        check("lost_at_timeout", int'(lost), 1);
        m_lost = 1'b1;
        check_held("after_timeout");
        repeat (50) @(negedge clk);
        pulse(1000, 800);
        check_held("resumed");

        // Reset halfway through a 1.5 ms-equivalent high time.
        @(negedge clk);
        pwm_in = 1'b1;
        repeat (375) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_width", int'(width_cyc), 0);
        check("midrst_pos", int'(pos_code), 3'b010);
        check("midrst_lost", int'(lost), 1);
        check("midrst_valid", int'(valid), 0);
        m_width = 0;
        m_pos   = 3'b010;
        m_lost  = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (370) @(negedge clk);
        pwm_in = 1'b0;
        repeat (800) @(negedge clk);
        check_held("after_truncated");
        pulse(750, 800);
        check_held("after_reset_pulse");

        repeat (20) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
